ram8: RTL



---
 rtl/hack_pkg.sv | 8 +
 rtl/ram8_if.sv | 14 +
 rtl/dmux_8_way.sv | 25 ++
 rtl/mux_8_way_16.sv | 31 +++
 rtl/register.sv | 16 +
 rtl/ram8.sv | 51 +++++
 6 files changed

// File: rtl/hack_pkg.sv
// Shared constants and types for the memory hierarchy (ram8, ram64, pc).
package hack_pkg;
    localparam int WORD_W      = 16;
    localparam int RAM8_DEPTH  = 8;
    localparam int RAM8_ADDR_W = 3;

    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/ram8_if.sv
// Data/address bus of the eight-word RAM; master drives, slave (the RAM) answers.
interface ram8_if
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
);
    logic [WIDTH-1:0]       in;
    logic                   load;
    logic [RAM8_ADDR_W-1:0] address;
    logic [WIDTH-1:0]       out;

    modport master (output in, load, address, input out);
    modport slave  (input in, load, address, output out);
endinterface

// File: rtl/dmux_8_way.sv
// Routes a single input to one of eight outputs selected by sel; others are 0.
module dmux_8_way (
    input  logic       in,
    input  logic [2:0] sel,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h
);
    // One-hot steering of in onto the selected output.
    always_comb begin
        a = in && (sel == 3'd0);
        b = in && (sel == 3'd1);
        c = in && (sel == 3'd2);
        d = in && (sel == 3'd3);
        e = in && (sel == 3'd4);
        f = in && (sel == 3'd5);
        g = in && (sel == 3'd6);
        h = in && (sel == 3'd7);
    end
endmodule

// File: rtl/mux_8_way_16.sv
// Eight-input word multiplexer selected by sel.
module mux_8_way_16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] out
);
    // Pure combinational selection.
    always_comb begin
        out = a;
        case (sel)
            3'd0: out = a;
            3'd1: out = b;
            3'd2: out = c;
            3'd3: out = d;
            3'd4: out = e;
            3'd5: out = f;
            3'd6: out = g;
            3'd7: out = h;
            default: out = a;
        endcase
    end
endmodule

// File: rtl/register.sv
// WIDTH-bit register with synchronous clear and load enable.
module register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);
    // Clear has priority over load; otherwise hold.
    always_ff @(posedge clk) begin
        if (reset)     out <= '0;
        else if (load) out <= in;
    end
endmodule

// File: rtl/ram8.sv
// Eight-word RAM: dmux decodes load into per-word enables, eight registers
// hold the words, and an unregistered mux returns word[address].
module ram8
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic   clk,
    input  logic   reset,
    ram8_if.slave  bus
);
    logic [RAM8_DEPTH-1:0]            en;
    logic [RAM8_DEPTH-1:0][WIDTH-1:0] word_q;

    dmux_8_way u_dec (
        .in  (bus.load),
        .sel (bus.address),
        .a   (en[0]),
        .b   (en[1]),
        .c   (en[2]),
        .d   (en[3]),
        .e   (en[4]),
        .f   (en[5]),
        .g   (en[6]),
        .h   (en[7])
    );

    for (genvar i = 0; i < RAM8_DEPTH; i++) begin : g_word
        register #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .load  (en[i]),
            .in    (bus.in),
            .out   (word_q[i])
        );
    end

    // Read path has no bypass: a same-cycle write shows up only after the edge.
    mux_8_way_16 #(.WIDTH(WIDTH)) u_rd (
        .a   (word_q[0]),
        .b   (word_q[1]),
        .c   (word_q[2]),
        .d   (word_q[3]),
        .e   (word_q[4]),
        .f   (word_q[5]),
        .g   (word_q[6]),
        .h   (word_q[7]),
        .sel (bus.address),
        .out (bus.out)
    );
endmodule
